// File: rtl/alu_formula_seq.sv
// Sequencer that evaluates (A op B) op C as two passes through an external 4-bit
// 74181-style ALU, latching carry/borrow of each pass and a zero flag.
module alu_formula_seq #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_sel,
    input  logic [DATA_W-1:0] Aop,
    input  logic [DATA_W-1:0] Bop,
    input  logic [DATA_W-1:0] Cop,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic [3:0]        Sin,
    output logic              M,
    output logic              NotCi,
    input  logic [DATA_W-1:0] Yout,
    input  logic              NotC0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Rout,
    output logic              f1,
    output logic              f2,
    output logic              zf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STEP1 = 2'd1;
    localparam logic [1:0] ST_STEP2 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] SIN_ADD  = 4'b1001;
    localparam logic [3:0] SIN_SUB  = 4'b0110;
    localparam logic [3:0] SIN_IDLE = 4'b1111;

    logic [1:0]        state;
    logic [1:0]        op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] c_r;
    logic [DATA_W-1:0] t_r;

    logic step1_sub;
    logic step2_sub;
    logic cur_sub;
    logic cur_flag;

    // Step 1 subtracts for formulas 01/11; step 2 subtracts for 00/11.
    assign step1_sub = op_r[0];
    assign step2_sub = ~(op_r[1] ^ op_r[0]);

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        Ain     = '0;
        Bin     = '0;
        Sin     = SIN_IDLE;
        M       = 1'b1;
        NotCi   = 1'b1;
        cur_sub = 1'b0;
        case (state)
            ST_STEP1: begin
                Ain     = a_r;
                Bin     = b_r;
                cur_sub = step1_sub;
                Sin     = step1_sub ? SIN_SUB : SIN_ADD;
                M       = 1'b0;
                NotCi   = ~step1_sub;
            end
            ST_STEP2: begin
                Ain     = t_r;
                Bin     = c_r;
                cur_sub = step2_sub;
                Sin     = step2_sub ? SIN_SUB : SIN_ADD;
                M       = 1'b0;
                NotCi   = ~step2_sub;
            end
            default: ;
        endcase
    end

    // The ALU's carry-out is active-low: low means carry on ADD, high means borrow on SUB.
    assign cur_flag = cur_sub ? NotC0 : ~NotC0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            t_r   <= '0;
            Rout  <= '0;
            f1    <= 1'b0;
            f2    <= 1'b0;
            zf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r  <= op_sel;
                        a_r   <= Aop;
                        b_r   <= Bop;
                        c_r   <= Cop;
                        state <= ST_STEP1;
                    end
                end
                ST_STEP1: begin
                    t_r   <= Yout;
                    f1    <= cur_flag;
                    state <= ST_STEP2;
                end
                ST_STEP2: begin
                    Rout  <= Yout;
                    f2    <= cur_flag;
                    zf    <= (Yout == '0);
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_formula_seq.sv
// Bench for alu_formula_seq: behavioural 74181 stand-in plus formula-level reference model.
module tb_alu_formula_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op_sel;
    logic [3:0] Aop, Bop, Cop;
    logic [3:0] Ain, Bin, Sin;
    logic       M, NotCi;
    logic [3:0] Yout;
    logic       NotC0;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Rout;
    logic       f1, f2, zf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_formula_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .Aop(Aop), .Bop(Bop), .Cop(Cop),
        .Ain(Ain), .Bin(Bin), .Sin(Sin), .M(M), .NotCi(NotCi),
        .Yout(Yout), .NotC0(NotC0), .out_valid(out_valid), .out_ready(out_ready),
        .Rout(Rout), .f1(f1), .f2(f2), .zf(zf)
    );

    // Arithmetic-mode 74181 (active-high data): A plus B, or A minus B via A + ~B + carry.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, Ain};
        Yout    = Ain;
        NotC0   = 1'b1;
        if (!M && Sin == 4'b1001) begin
            alu_sum = {1'b0, Ain} + {1'b0, Bin} + {4'b0, ~NotCi};
            Yout    = alu_sum[3:0];
            NotC0   = ~alu_sum[4];
        end else if (!M && Sin == 4'b0110) begin
            alu_sum = {1'b0, Ain} + {1'b0, ~Bin} + {4'b0, ~NotCi};
            Yout    = alu_sum[3:0];
            NotC0   = ~alu_sum[4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit step1_is_sub(input logic [1:0] op);
        return (op == 2'b01 || op == 2'b11);
    endfunction

    function automatic bit step2_is_sub(input logic [1:0] op);
        return (op == 2'b00 || op == 2'b11);
    endfunction

    // Reference: formula evaluated with integer arithmetic, flags = out-of-range of each step.
    task automatic ref_calc(input logic [1:0] op, input int a, input int b, input int c,
                            output logic [3:0] r, output logic e1, output logic e2,
                            output logic ez);
        int s1, s2, t;
        s1 = step1_is_sub(op) ? a - b : a + b;
        e1 = (s1 > 15) || (s1 < 0);
        t  = s1 & 15;
        s2 = step2_is_sub(op) ? t - c : t + c;
        e2 = (s2 > 15) || (s2 < 0);
        r  = 4'(s2 & 15);
        ez = (r == 4'd0);
    endtask

    task automatic chk_code(input string tag, input bit sub, input logic [3:0] ea,
                            input logic [3:0] eb);
        chk({tag, "_sin"}, Sin, sub ? 4'b0110 : 4'b1001);
        chk({tag, "_m"}, M, 1'b0);
        chk({tag, "_nci"}, NotCi, sub ? 1'b0 : 1'b1);
        chk({tag, "_ain"}, Ain, ea);
        chk({tag, "_bin"}, Bin, eb);
    endtask

    task automatic chk_idle_code(input string tag);
        chk({tag, "_sin"}, Sin, 4'b1111);
        chk({tag, "_m"}, M, 1'b1);
        chk({tag, "_nci"}, NotCi, 1'b1);
        chk({tag, "_ab"}, {Ain, Bin}, 8'h00);
    endtask

    // One full transaction starting in IDLE at a negedge; hold = cycles out_ready stays low in DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c, input int hold);
        logic [3:0] er;
        logic e1, e2, ez;
        logic [3:0] t;
        ref_calc(op, a, b, c, er, e1, e2, ez);
        t = step1_is_sub(op) ? a - b : a + b;
        chk({tag, "_rdy"}, in_ready, 1'b1);
        in_valid = 1'b1; op_sel = op; Aop = a; Bop = b; Cop = c;
        step();
        in_valid = 1'b0;
        Aop = ~a; Bop = ~b; Cop = ~c; op_sel = ~op;
        chk({tag, "_s1_vld"}, {in_ready, out_valid}, 2'b00);
        chk_code({tag, "_s1"}, step1_is_sub(op), a, b);
        step();
        chk({tag, "_s2_vld"}, out_valid, 1'b0);
        chk_code({tag, "_s2"}, step2_is_sub(op), t, c);
        step();
        chk({tag, "_done_vld"}, {in_ready, out_valid}, 2'b01);
        chk({tag, "_res"}, {Rout, f1, f2, zf}, {er, e1, e2, ez});
        chk_idle_code({tag, "_done"});
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0]; Aop = 4'(i); op_sel = 2'(i);
            step();
            chk({tag, "_hold_vld"}, {in_ready, out_valid}, 2'b01);
            chk({tag, "_hold_res"}, {Rout, f1, f2, zf}, {er, e1, e2, ez});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
        chk({tag, "_idle_res"}, {Rout, f1, f2, zf}, {er, e1, e2, ez});
    endtask

    initial begin
        logic [3:0] er, ra, rb, rc;
        logic [1:0] rop;
        logic e1, e2, ez;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_sel = 2'b00; Aop = 4'h0; Bop = 4'h0; Cop = 4'h0;
        step(); step();
        rst = 1'b0;
        chk("reset_hs", {in_ready, out_valid}, 2'b10);
        chk("reset_res", {Rout, f1, f2, zf}, 7'h00);
        chk_idle_code("reset");

        run_op("v029", 2'b00, 4'h9, 4'h8, 4'h3, 0);
        run_op("v030", 2'b01, 4'h5, 4'h2, 4'h4, 0);
        run_op("v031", 2'b10, 4'hF, 4'h1, 4'h0, 0);
        run_op("v032", 2'b11, 4'h2, 4'h3, 4'h1, 5);

        // Abort in STEP2 by reset, then a fresh operation.
        in_valid = 1'b1; op_sel = 2'b10; Aop = 4'h7; Bop = 4'h6; Cop = 4'h5;
        step();
        in_valid = 1'b0;
        step();
        chk("abort_in_s2", Sin, 4'b1001);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        chk("abort_hs", {in_ready, out_valid}, 2'b10);
        chk("abort_res", {Rout, f1, f2, zf}, 7'h00);
        step();
        chk("abort_stay_idle", {in_ready, out_valid}, 2'b10);
        run_op("v033", 2'b00, 4'h1, 4'h1, 4'h1, 0);

        // Back-to-back: in_valid and out_ready held high, one accept every 4 cycles.
        in_valid = 1'b1; out_ready = 1'b1;
        rop = 2'b00; ra = 4'h0; rb = 4'h0; rc = 4'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            chk("b2b_rdy", in_ready, (cyc % 4 == 0) ? 1'b1 : 1'b0);
            chk("b2b_vld", out_valid, (cyc % 4 == 3) ? 1'b1 : 1'b0);
            if (cyc % 4 == 0) begin
                rop = 2'($urandom_range(0, 3));
                ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
                op_sel = rop; Aop = ra; Bop = rb; Cop = rc;
            end else begin
                op_sel = 2'($urandom); Aop = 4'($urandom); Bop = 4'($urandom);
                Cop = 4'($urandom);
            end
            if (cyc % 4 == 1) chk("b2b_s1_sin", Sin, step1_is_sub(rop) ? 4'b0110 : 4'b1001);
            if (cyc % 4 == 2) chk("b2b_s2_sin", Sin, step2_is_sub(rop) ? 4'b0110 : 4'b1001);
            if (cyc % 4 == 3) begin
                ref_calc(rop, ra, rb, rc, er, e1, e2, ez);
                chk("b2b_res", {Rout, f1, f2, zf}, {er, e1, e2, ez});
                chk_idle_code("b2b_done");
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        step();

        for (int n = 0; n < 24; n++) begin
            run_op("rand", 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                   4'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_formula_seq.md
ALU_FORMULA_SEQ -- requirements
Module: alu_formula_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  operand set and op_sel presented.
REQ-004 in_ready  output  1  block accepts operands this cycle.
REQ-005 op_sel  input  2  formula: 00 (A+B)-C, 01 (A-B)+C, 10 (A+B)+C, 11 (A-B)-C.
REQ-006 Aop, Bop, Cop  input  4 each  unsigned operands.
REQ-007 Ain, Bin  output  4 each  operands driven to the 4-bit ALU.
REQ-008 Sin  output  4  ALU function select; M output 1 mode; NotCi output 1 active-low carry-in.
REQ-009 Yout  input  4  ALU result; NotC0 input 1 ALU active-low carry-out.
REQ-010 out_valid  output  1  result held and valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 Rout  output  4  formula result, modulo 16.
REQ-013 f1, f2  output  1 each  step-1 / step-2 carry-or-borrow flag; zf output 1, Rout==0.

Function
REQ-014 ALU codes: ADD = Sin 1001, M 0, NotCi 1; SUB = Sin 0110, M 0, NotCi 0; IDLE = Sin 1111, M 1, NotCi 1, Ain=Bin=0000.
REQ-015 Flag rule: after ADD, flag = ~NotC0 (carry); after SUB, flag = NotC0 (borrow).
REQ-016 States: IDLE, STEP1, STEP2, DONE; encoding free.
REQ-017 in_ready = 1 only in IDLE; in_valid outside IDLE is ignored, no operand latch.
REQ-018 IDLE & in_valid at edge k: latch Aop/Bop/Cop/op_sel into internal regs, go STEP1.
REQ-019 STEP1: Ain=A, Bin=B, op = ADD if op_sel in {00,10} else SUB; at edge, T<=Yout, f1 per REQ-015, go STEP2.
REQ-020 STEP2: Ain=T, Bin=C, op = ADD if op_sel in {01,10} else SUB; at edge, Rout<=Yout, f2 per REQ-015, zf<=(Yout==0), go DONE.
REQ-021 ALU drive outputs are decoded from state and internal regs only; IDLE and DONE drive IDLE code.
REQ-022 Latency: out_valid = 1 in the cycle after edge k+2; out_valid = 1 exactly in DONE.
REQ-023 DONE: Rout, f1, f2, zf hold stable; out_ready=1 at an edge -> IDLE; otherwise remain DONE indefinitely.
REQ-024 out_ready in the first DONE cycle completes the handshake at that edge; out_ready outside DONE is ignored.
REQ-025 No overlap: next accept earliest in IDLE after DONE exits; back-to-back throughput 1 result / 4 cycles.
REQ-026 Rout/f1/f2/zf update only at the STEP2 edge; unchanged in IDLE, STEP1, DONE.

Reset
REQ-027 rst=1 at an edge: state IDLE; Rout=0000, f1=f2=0, zf=0, out_valid=0, internal regs 0; overrides all other inputs.
REQ-028 Reset in STEP1/STEP2/DONE aborts the operation; no partial result appears; in_ready=1 in the first cycle after reset release.

Verification
REQ-029 op 00, A=9 B=8 C=3 -> step1 T=1 f1=1; Rout=1110 f2=1 zf=0, out_valid 2 cycles after accept.
REQ-030 op 01, A=5 B=2 C=4 -> Rout=0111 f1=0 f2=0 zf=0.
REQ-031 op 10, A=F B=1 C=0 -> Rout=0000 f1=1 f2=0 zf=1.
REQ-032 op 11, A=2 B=3 C=1 -> Rout=1110 f1=1 f2=0; out_ready low 5 cycles -> outputs held, in_valid pulses ignored.
REQ-033 rst asserted during STEP2 -> next cycle IDLE, out_valid=0, Rout=0000; fresh op 00 A=1 B=1 C=1 -> Rout=0001.
REQ-034 in_valid held high with out_ready high -> accepts at cycles 0,4,8; ALU Sin/M/NotCi match REQ-014 each step.
